// File: rtl/mux_nx1_scan_reg.sv
// N-channel registered multiplexer with direct-select and round-robin scan modes.
// Output sits behind a valid/ready register stage with one cycle of latency.
module mux_nx1_scan_reg #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid
);
  localparam int DW = $clog2(DWELL) + 1;
  // Index compares carry one extra bit so CHANNELS == 2**SEL_W does not wrap.
  localparam logic [SEL_W:0]  CH_LAST    = (SEL_W+1)'(CHANNELS - 1);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic {DIRECT, SCAN} state_t;

  state_t                         state, state_next;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_arr;
  logic [SEL_W-1:0]               scan_ptr, ch_next;
  logic [DW-1:0]                  dwell_cnt;
  logic                           load, scan_enter, scan_load, ptr_last;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch_arr[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign load       = en && (!out_valid || out_ready);
  assign scan_enter = (state == DIRECT) && mode;
  assign scan_load  = load && (state == SCAN);
  assign ptr_last   = ({1'b0, scan_ptr} == CH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIRECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIRECT: if (mode)  state_next = SCAN;
      SCAN:   if (!mode) state_next = DIRECT;
      default:           state_next = DIRECT;
    endcase
  end

  // Channel choice follows the registered state, so a mode flip takes effect a cycle later.
  always_comb begin
    ch_next = sel;
    if (state == SCAN)
      ch_next = scan_ptr;
    else if ({1'b0, sel} > CH_LAST)
      ch_next = CH_LAST[SEL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= ch_arr[ch_next];
      out_ch    <= ch_next;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr  <= '0;
      dwell_cnt <= '0;
    end else if (scan_enter) begin
      scan_ptr  <= '0;
      dwell_cnt <= '0;
    end else if (scan_load) begin
      if (dwell_cnt == DWELL_LAST) begin
        dwell_cnt <= '0;
        scan_ptr  <= ptr_last ? '0 : scan_ptr + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_nx1_scan_reg.sv
// Directed bench for mux_nx1_scan_reg: default 4x2 (DWELL=1), a DWELL=2 scanner
// and a 3-channel instance for clamp and non-power-of-2 wrap.
module tb_mux_nx1_scan_reg;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [5:0] in_data3;
  logic [1:0] sel;
  logic       mode, en, out_ready;

  logic [1:0] d_data, s_data, c_data;
  logic [1:0] d_ch, s_ch, c_ch;
  logic       d_valid, s_valid, c_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_nx1_scan_reg #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .DWELL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .mode(mode), .en(en),
    .out_ready(out_ready), .out_data(d_data), .out_ch(d_ch), .out_valid(d_valid));

  mux_nx1_scan_reg #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .DWELL(2)) u_scan (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .mode(mode), .en(en),
    .out_ready(out_ready), .out_data(s_data), .out_ch(s_ch), .out_valid(s_valid));

  mux_nx1_scan_reg #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .DWELL(1)) u_clamp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel), .mode(mode), .en(en),
    .out_ready(out_ready), .out_data(c_data), .out_ch(c_ch), .out_valid(c_valid));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; out_ready = 1'b1; sel = 2'd0;
    in_data = 8'h00; in_data3 = 6'h00;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({d_valid, s_valid, c_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle valids=%b expected 000", {d_valid, s_valid, c_valid});
    end
    in_data = 8'hFF; sel = 2'd3; en = 1'b1;
    step();
    checks++;
    if ({d_valid, d_ch, d_data} !== {1'b1, 2'd3, 2'b11}) begin
      failures++;
      $display("FAIL reset_preload got v=%b ch=%0d d=%b expected v=1 ch=3 d=11", d_valid, d_ch, d_data);
    end
    // Async reset asserted mid-cycle with scrambled inputs.
    @(negedge clk);
    in_data = 8'($urandom); sel = 2'($urandom); mode = 1'($urandom);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d_valid, d_ch, d_data} !== 5'b0) begin
      failures++;
      $display("FAIL reset_async got v=%b ch=%0d d=%b expected all zero", d_valid, d_ch, d_data);
    end
    en = 1'b0; mode = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({d_valid, s_valid, c_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release valids=%b expected 000", {d_valid, s_valid, c_valid});
    end
  endtask

  task automatic test_direct();
    logic [1:0] sels [3] = '{2'd0, 2'd3, 2'd1};
    in_data = 8'hE4; mode = 1'b0; en = 1'b1; out_ready = 1'b1; sel = 2'd2;
    step();
    checks++;
    if ({d_valid, d_ch, d_data} !== {1'b1, 2'd2, 2'b10}) begin
      failures++;
      $display("FAIL direct_sel2 got v=%b ch=%0d d=%b expected v=1 ch=2 d=10", d_valid, d_ch, d_data);
    end
    // Back-to-back loads: a new channel every cycle, valid never drops.
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      step();
      checks++;
      if ({d_valid, d_ch, d_data} !== {1'b1, sels[i], sels[i]}) begin
        failures++;
        $display("FAIL back_to_back[%0d] got v=%b ch=%0d d=%b expected v=1 ch=%0d", i, d_valid, d_ch, d_data, sels[i]);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (d_valid !== 1'b0) begin
      failures++;
      $display("FAIL direct_drain got valid=%b expected 0", d_valid);
    end
  endtask

  task automatic test_backpressure();
    in_data = 8'hE4; sel = 2'd1; en = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_data = 8'hEC; sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({d_valid, d_ch, d_data} !== {1'b1, 2'd1, 2'b01}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got v=%b ch=%0d d=%b expected v=1 ch=1 d=01", i, d_valid, d_ch, d_data);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({d_valid, d_ch, d_data} !== {1'b1, 2'd3, 2'b11}) begin
      failures++;
      $display("FAIL stall_release got v=%b ch=%0d d=%b expected v=1 ch=3 d=11", d_valid, d_ch, d_data);
    end
    en = 1'b0; out_ready = 1'b0;
    step();
    checks++;
    if ({d_valid, d_data} !== {1'b1, 2'b11}) begin
      failures++;
      $display("FAIL en_low_retain got v=%b d=%b expected v=1 d=11", d_valid, d_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (d_valid !== 1'b0) begin
      failures++;
      $display("FAIL en_low_accept got valid=%b expected 0", d_valid);
    end
  endtask

  task automatic test_scan_wrap();
    logic [1:0] s_exp [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    in_data = 8'hE4; in_data3 = 6'b10_01_00; sel = 2'd1; out_ready = 1'b1;
    en = 1'b0; mode = 1'b1;
    step();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({s_valid, s_ch, s_data} !== {1'b1, s_exp[i], s_exp[i]}) begin
        failures++;
        $display("FAIL scan_dwell2[%0d] got v=%b ch=%0d d=%b expected ch=%0d", i, s_valid, s_ch, s_data, s_exp[i]);
      end
      checks++;
      if ({d_ch, c_ch} !== {2'(i % 4), 2'(i % 3)}) begin
        failures++;
        $display("FAIL scan_dwell1[%0d] got ch4=%0d ch3=%0d expected %0d %0d", i, d_ch, c_ch, i % 4, i % 3);
      end
    end
    // Stalled scan must not advance the pointer.
    out_ready = 1'b0;
    step(); step(); step();
    out_ready = 1'b1;
    step();
    checks++;
    if (d_ch !== 2'd2) begin
      failures++;
      $display("FAIL scan_stall got ch=%0d expected 2", d_ch);
    end
    // Mode flip cycle still uses the scan pointer; direct select applies after.
    mode = 1'b0;
    step();
    checks++;
    if (d_ch !== 2'd3) begin
      failures++;
      $display("FAIL mode_flip_old got ch=%0d expected 3", d_ch);
    end
    step();
    checks++;
    if (d_ch !== 2'd1) begin
      failures++;
      $display("FAIL mode_flip_new got ch=%0d expected 1", d_ch);
    end
  endtask

  task automatic test_clamp();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1; in_data3 = 6'b10_01_00; in_data = 8'hE4;
    sel = 2'd3;
    step();
    checks++;
    if ({c_valid, c_ch, c_data} !== {1'b1, 2'd2, 2'b10}) begin
      failures++;
      $display("FAIL clamp_sel3 got v=%b ch=%0d d=%b expected v=1 ch=2 d=10", c_valid, c_ch, c_data);
    end
    checks++;
    if ({d_ch, d_data} !== {2'd3, 2'b11}) begin
      failures++;
      $display("FAIL noclamp_sel3 got ch=%0d d=%b expected ch=3 d=11", d_ch, d_data);
    end
    sel = 2'd1;
    step();
    checks++;
    if ({c_ch, c_data} !== {2'd1, 2'b01}) begin
      failures++;
      $display("FAIL clamp_sel1 got ch=%0d d=%b expected ch=1 d=01", c_ch, c_data);
    end
  endtask

  task automatic test_reset_mid_scan();
    in_data = 8'hE4; out_ready = 1'b1; en = 1'b0; mode = 1'b1; sel = 2'd3;
    step();
    en = 1'b1;
    repeat (5) step();
    checks++;
    if ({s_ch, s_data} !== {2'd2, 2'b10}) begin
      failures++;
      $display("FAIL midscan_pos got ch=%0d d=%b expected ch=2 d=10", s_ch, s_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_valid, s_ch} !== 3'b000) begin
      failures++;
      $display("FAIL midscan_reset got v=%b ch=%0d expected 0 0", s_valid, s_ch);
    end
    en = 1'b0; in_data = 8'h1B;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL midscan_release got valid=%b expected 0", s_valid);
    end
    en = 1'b1;
    step();
    checks++;
    if ({s_valid, s_ch, s_data} !== {1'b1, 2'd0, 2'b11}) begin
      failures++;
      $display("FAIL midscan_first got v=%b ch=%0d d=%b expected v=1 ch=0 d=11", s_valid, s_ch, s_data);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_backpressure();
    test_scan_wrap();
    test_clamp();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
